// File: rtl/sparse_map_decoder_p.sv
// Chained sparse-map block decoder: fetches map + packed values, emits (row, col, value) via a FIFO.
// Optional dense mode (every column emitted, clear bits as zero): define SMDEC_ZERO_EMIT_EN.
module sparse_map_decoder_p #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int ROW_W      = 10,
  parameter int COL_W      = 16,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int NMAP_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            start_address,
  input  logic [ROW_W-1:0]             start_row,
  input  logic [COL_W-1:0]             start_col,
  input  logic [NMAP_W-1:0]            num_maps,
  input  logic                         op_start,
  output logic                         busy,
  input  logic                         pxMem_GRANT,
  output logic                         pxMem_RD_REQ,
  output logic [ADDR_W-1:0]            pxMem_Addr,
  output logic [$clog2(MAX_BURST):0]   px_burst,
  input  logic                         pxMem_RD_VLD,
  output logic                         pxMem_RD_RDY,
  input  logic [DATA_W-1:0]            pxMem_in,
  input  logic                         px_RDY,
  output logic                         px_VLD,
  output logic [DATA_W-1:0]            px_value_out,
  output logic [ROW_W-1:0]             px_row,
  output logic [COL_W-1:0]             px_col
);

  localparam int BURST_W = $clog2(MAX_BURST) + 1;
  localparam int CNT_W   = $clog2(DATA_W) + 1;
  localparam int IDX_W   = $clog2(DATA_W);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = COL_W + DATA_W;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_MAP, S_CMD_MAP, S_RD_MAP, S_COUNT,
    S_REQ_VAL, S_CMD_VAL, S_RD_VAL, S_NEXT, S_DRAIN
  } state_t;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    addr_ptr;
  logic [ROW_W-1:0]     row_q;
  logic [COL_W-1:0]     base_q;
  logic [NMAP_W-1:0]    blocks_left;
  logic [CNT_W-1:0]     remaining;
  logic [BURST_W-1:0]   burst_left, val_len;
  logic [DATA_W-1:0]    map_q, scan;
  logic [IDX_W-1:0]     cur_idx;
  logic                 word_needed, zero_push, rd_acc, val_acc, push, pop, space_ok;

  logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]    fifo_cnt, fifo_free;
  logic                 fifo_full;
  logic [ENTRY_W-1:0]   fifo_head;

  function automatic logic [CNT_W-1:0] popcount(input logic [DATA_W-1:0] w);
    popcount = '0;
    for (int i = 0; i < DATA_W; i++) popcount = popcount + CNT_W'(w[i]);
  endfunction

`ifdef SMDEC_ZERO_EMIT_EN
  logic [IDX_W-1:0] bit_idx;
  assign cur_idx     = bit_idx;
  assign word_needed = scan[bit_idx] && (burst_left != '0);
  assign zero_push   = (state == S_RD_VAL) && !scan[bit_idx] && !fifo_full;
`else
  function automatic logic [IDX_W-1:0] lowest_set(input logic [DATA_W-1:0] w);
    lowest_set = '0;
    for (int i = DATA_W - 1; i >= 0; i--) if (w[i]) lowest_set = IDX_W'(i);
  endfunction
  assign cur_idx     = lowest_set(scan);
  assign word_needed = (burst_left != '0);
  assign zero_push   = 1'b0;
`endif

  assign fifo_full    = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
  assign fifo_free    = FCNT_W'(FIFO_DEPTH) - fifo_cnt;
  assign val_len      = (int'(remaining) > MAX_BURST) ? BURST_W'(MAX_BURST) : BURST_W'(remaining);
  assign space_ok     = int'(fifo_free) >= int'(val_len);
  assign pxMem_RD_RDY = ((state == S_RD_MAP) || ((state == S_RD_VAL) && word_needed)) && !fifo_full;
  assign rd_acc       = pxMem_RD_VLD && pxMem_RD_RDY;
  assign val_acc      = rd_acc && (state == S_RD_VAL);
  assign push         = val_acc || zero_push;
  assign pop          = px_VLD && px_RDY;
  assign busy         = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (op_start) state_nxt = S_REQ_MAP;
      S_REQ_MAP: if (pxMem_GRANT) state_nxt = S_CMD_MAP;
      S_CMD_MAP: state_nxt = S_RD_MAP;
      S_RD_MAP:  if (rd_acc) state_nxt = S_COUNT;
`ifdef SMDEC_ZERO_EMIT_EN
      S_COUNT:   state_nxt = (map_q == '0) ? S_RD_VAL : S_REQ_VAL;
`else
      S_COUNT:   state_nxt = (map_q == '0) ? S_NEXT : S_REQ_VAL;
`endif
      S_REQ_VAL: if (pxMem_GRANT && space_ok) state_nxt = S_CMD_VAL;
      S_CMD_VAL: state_nxt = S_RD_VAL;
`ifdef SMDEC_ZERO_EMIT_EN
      S_RD_VAL: begin
        if (push && bit_idx == IDX_W'(DATA_W - 1))      state_nxt = S_NEXT;
        else if (scan[bit_idx] && burst_left == '0)     state_nxt = S_REQ_VAL;
      end
`else
      S_RD_VAL:  if (val_acc && burst_left == BURST_W'(1))
                   state_nxt = (remaining == CNT_W'(1)) ? S_NEXT : S_REQ_VAL;
`endif
      S_NEXT:    state_nxt = (blocks_left > NMAP_W'(1)) ? S_REQ_MAP : S_DRAIN;
      S_DRAIN:   if (fifo_cnt == '0) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Request stays up from REQ through the last word of the burst.
  always_comb begin
    pxMem_RD_REQ = 1'b0;
    pxMem_Addr   = '0;
    px_burst     = '0;
    unique case (state)
      S_REQ_MAP:          pxMem_RD_REQ = 1'b1;
      S_REQ_VAL:          pxMem_RD_REQ = space_ok;
      S_CMD_MAP: begin
        pxMem_RD_REQ = 1'b1;
        pxMem_Addr   = addr_ptr;
        px_burst     = BURST_W'(1);
      end
      S_CMD_VAL: begin
        pxMem_RD_REQ = 1'b1;
        pxMem_Addr   = addr_ptr;
        px_burst     = val_len;
      end
      S_RD_MAP, S_RD_VAL: pxMem_RD_REQ = (burst_left != '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_ptr    <= '0;
      row_q       <= '0;
      base_q      <= '0;
      blocks_left <= '0;
      remaining   <= '0;
      burst_left  <= '0;
      map_q       <= '0;
      scan        <= '0;
`ifdef SMDEC_ZERO_EMIT_EN
      bit_idx     <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: if (op_start) begin
          addr_ptr    <= start_address;
          row_q       <= start_row;
          base_q      <= start_col;
          blocks_left <= (num_maps == '0) ? NMAP_W'(1) : num_maps;
        end
        S_CMD_MAP: burst_left <= BURST_W'(1);
        S_CMD_VAL: burst_left <= val_len;
        S_COUNT: begin
          remaining  <= popcount(map_q);
          scan       <= map_q;
          burst_left <= '0;
`ifdef SMDEC_ZERO_EMIT_EN
          bit_idx    <= '0;
`endif
        end
        S_NEXT: begin
          base_q      <= base_q + COL_W'(DATA_W);
          blocks_left <= blocks_left - NMAP_W'(1);
        end
        default: ;
      endcase
      if (rd_acc) begin
        addr_ptr   <= addr_ptr + ADDR_W'(1);
        burst_left <= burst_left - BURST_W'(1);
      end
      if (rd_acc && state == S_RD_MAP) map_q <= pxMem_in;
      if (val_acc) remaining <= remaining - CNT_W'(1);
`ifdef SMDEC_ZERO_EMIT_EN
      if (push) bit_idx <= bit_idx + IDX_W'(1);
`else
      if (val_acc) scan[cur_idx] <= 1'b0;
`endif
    end
  end

  // NOTE: FIFO storage has no reset; only pointers/count are reset and outputs are gated by px_VLD.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {base_q + COL_W'(cur_idx), val_acc ? pxMem_in : DATA_W'(0)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
        default: ;
      endcase
    end
  end

  assign fifo_head    = fifo_mem[rd_ptr];
  assign px_VLD       = (fifo_cnt != '0);
  assign px_value_out = px_VLD ? fifo_head[DATA_W-1:0] : '0;
  assign px_col       = px_VLD ? fifo_head[DATA_W +: COL_W] : '0;
  assign px_row       = px_VLD ? row_q : '0;

endmodule

// File: tb/tb_sparse_map_decoder_p.sv
// Directed bench for sparse_map_decoder_p: memory slave, pixel sink, hand-computed expectations.
module tb_sparse_map_decoder_p;
  localparam int DATA_W = 16, ADDR_W = 16, ROW_W = 10, COL_W = 16;
  localparam int MAX_BURST = 16, FIFO_DEPTH = 16, NMAP_W = 8;
  localparam int BURST_W = $clog2(MAX_BURST) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ADDR_W-1:0]  start_address = '0;
  logic [ROW_W-1:0]   start_row = '0;
  logic [COL_W-1:0]   start_col = '0;
  logic [NMAP_W-1:0]  num_maps = '0;
  logic               op_start = 1'b0;
  logic               busy;
  logic               pxMem_GRANT = 1'b0;
  logic               pxMem_RD_REQ;
  logic [ADDR_W-1:0]  pxMem_Addr;
  logic [BURST_W-1:0] px_burst;
  logic               pxMem_RD_VLD = 1'b0;
  logic               pxMem_RD_RDY;
  logic [DATA_W-1:0]  pxMem_in = '0;
  logic               px_RDY = 1'b0;
  logic               px_VLD;
  logic [DATA_W-1:0]  px_value_out;
  logic [ROW_W-1:0]   px_row;
  logic [COL_W-1:0]   px_col;

  sparse_map_decoder_p #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W), .COL_W(COL_W),
    .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH), .NMAP_W(NMAP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_address(start_address), .start_row(start_row), .start_col(start_col),
    .num_maps(num_maps), .op_start(op_start), .busy(busy),
    .pxMem_GRANT(pxMem_GRANT), .pxMem_RD_REQ(pxMem_RD_REQ), .pxMem_Addr(pxMem_Addr),
    .px_burst(px_burst), .pxMem_RD_VLD(pxMem_RD_VLD), .pxMem_RD_RDY(pxMem_RD_RDY),
    .pxMem_in(pxMem_in), .px_RDY(px_RDY), .px_VLD(px_VLD),
    .px_value_out(px_value_out), .px_row(px_row), .px_col(px_col)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem [65536];
  int                cmd_addr[$], cmd_len[$];
  int                exp_addr[$], exp_len[$];
  logic [COL_W-1:0]  got_col[$], exp_col[$];
  logic [DATA_W-1:0] got_val[$], exp_val[$];
  logic [ROW_W-1:0]  got_row[$];
  logic              vld_gaps = 1'b0;
  int                stab_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Memory slave: grants requests, logs commands, returns mem[] words for each burst.
  initial begin : mem_slave
    logic [ADDR_W-1:0] rd_addr;
    int  words_left, tick;
    logic acc_pend;
    rd_addr = '0; words_left = 0; tick = 0; acc_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        words_left = 0; acc_pend = 1'b0;
        pxMem_GRANT = 1'b0; pxMem_RD_VLD = 1'b0; pxMem_in = '0;
      end else begin
        if (acc_pend) begin
          rd_addr = rd_addr + 1'b1;
          words_left--;
        end
        if (px_burst != '0) begin
          cmd_addr.push_back(int'(pxMem_Addr));
          cmd_len.push_back(int'(px_burst));
          rd_addr = pxMem_Addr;
          words_left = int'(px_burst);
        end
        pxMem_GRANT = pxMem_RD_REQ && (words_left == 0);
        tick++;
        pxMem_RD_VLD = (words_left > 0) && (!vld_gaps || tick[0]);
        pxMem_in = pxMem_RD_VLD ? mem[rd_addr] : '0;
        acc_pend = pxMem_RD_VLD && pxMem_RD_RDY;
      end
    end
  end

  // Pixel sink: logs popped pixels and counts head changes while stalled.
  initial begin : px_sink
    logic prev_stall;
    logic [COL_W-1:0]  prev_col;
    logic [DATA_W-1:0] prev_val;
    prev_stall = 1'b0; prev_col = '0; prev_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 1'b0;
      else begin
        if (prev_stall && (!px_VLD || px_col != prev_col || px_value_out != prev_val)) stab_err++;
        if (px_VLD && px_RDY) begin
          got_col.push_back(px_col);
          got_val.push_back(px_value_out);
          got_row.push_back(px_row);
        end
        prev_stall = px_VLD && !px_RDY;
        prev_col = px_col;
        prev_val = px_value_out;
      end
    end
  end

  task automatic clear_logs();
    cmd_addr.delete(); cmd_len.delete(); exp_addr.delete(); exp_len.delete();
    got_col.delete(); got_val.delete(); got_row.delete(); exp_col.delete(); exp_val.delete();
  endtask

  task automatic start_op(input string tag, input logic [ADDR_W-1:0] a, input logic [ROW_W-1:0] r,
                          input logic [COL_W-1:0] c, input logic [NMAP_W-1:0] n);
    @(posedge clk); #1;
    start_address = a; start_row = r; start_col = c; num_maps = n; op_start = 1'b1;
    check({tag, "_busy_pre"}, busy, 1'b0);
    @(posedge clk); #1;
    op_start = 1'b0;
    start_address = 16'h5A5A; start_row = 10'h155; start_col = 16'hA5A5; num_maps = 8'd9;
    check({tag, "_busy_post"}, busy, 1'b1);
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic compare_all(input string tag, input logic [ROW_W-1:0] row);
    check({tag, "_ncmd"}, cmd_addr.size(), exp_addr.size());
    foreach (exp_addr[i]) if (i < cmd_addr.size()) begin
      check($sformatf("%s_cmd%0d_addr", tag, i), cmd_addr[i], exp_addr[i]);
      check($sformatf("%s_cmd%0d_len", tag, i), cmd_len[i], exp_len[i]);
    end
    check({tag, "_npix"}, got_col.size(), exp_col.size());
    foreach (exp_col[i]) if (i < got_col.size()) begin
      check($sformatf("%s_px%0d_col", tag, i), got_col[i], exp_col[i]);
      check($sformatf("%s_px%0d_val", tag, i), got_val[i], exp_val[i]);
      check($sformatf("%s_px%0d_row", tag, i), got_row[i], row);
    end
  endtask

  task automatic expect_case1();
    int cols[8] = '{5000, 5002, 5004, 5006, 5008, 5009, 5010, 5011};
    exp_addr = '{'hF7F7, 'hF7F8};
    exp_len  = '{1, 8};
    for (int i = 0; i < 8; i++) begin
      exp_col.push_back(COL_W'(cols[i]));
      exp_val.push_back(16'hA001 + DATA_W'(i));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_rdreq"}, pxMem_RD_REQ, 1'b0);
    check({tag, "_addr"}, pxMem_Addr, '0);
    check({tag, "_burst"}, px_burst, '0);
    check({tag, "_rdrdy"}, pxMem_RD_RDY, 1'b0);
    check({tag, "_vld"}, px_VLD, 1'b0);
    check({tag, "_val"}, px_value_out, '0);
    check({tag, "_row"}, px_row, '0);
    check({tag, "_col"}, px_col, '0);
  endtask

  initial begin : main
    int cyc;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'hF7F7] = 16'h0F55;
    for (int i = 0; i < 8; i++) mem[16'hF7F8 + i] = 16'hA001 + DATA_W'(i);
    mem[16'h1000] = 16'h0000;
    mem[16'h2000] = 16'h8001; mem[16'h2001] = 16'hB001; mem[16'h2002] = 16'hB002;
    mem[16'h2003] = 16'hFFFF;
    for (int i = 0; i < 16; i++) mem[16'h2004 + i] = 16'hC000 + DATA_W'(i);
    mem[16'h3000] = 16'hFFFF;
    for (int i = 0; i < 16; i++) mem[16'h3001 + i] = 16'hD000 + DATA_W'(i);
    mem[16'h4000] = 16'h0003; mem[16'h4001] = 16'hE001; mem[16'h4002] = 16'hE002;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    px_RDY = 1'b1;

    // Case 1: single block
    clear_logs();
    start_op("c1", 16'hF7F7, 10'd600, 16'd5000, 8'd1);
    wait_idle("c1", cyc);
    expect_case1();
    compare_all("c1", 10'd600);

    // Case 2: empty map, no value burst, fast busy fall
    clear_logs();
    start_op("c2", 16'h1000, 10'd3, 16'd0, 8'd1);
    wait_idle("c2", cyc);
    check("c2_busy_cycles_le6", cyc <= 6, 1'b1);
    exp_addr = '{'h1000};
    exp_len  = '{1};
    compare_all("c2", 10'd3);

    // Case 3: two chained blocks, VLD gaps from memory
    clear_logs();
    vld_gaps = 1'b1;
    start_op("c3", 16'h2000, 10'd7, 16'd0, 8'd2);
    wait_idle("c3", cyc);
    vld_gaps = 1'b0;
    exp_addr = '{'h2000, 'h2001, 'h2003, 'h2004};
    exp_len  = '{1, 2, 1, 16};
    exp_col.push_back(16'd0);  exp_val.push_back(16'hB001);
    exp_col.push_back(16'd15); exp_val.push_back(16'hB002);
    for (int i = 0; i < 16; i++) begin
      exp_col.push_back(16'd16 + COL_W'(i));
      exp_val.push_back(16'hC000 + DATA_W'(i));
    end
    compare_all("c3", 10'd7);

    // Case 4: downstream backpressure with a full FIFO
    clear_logs();
    px_RDY = 1'b0;
    stab_err = 0;
    start_op("c4", 16'h3000, 10'd1, 16'd100, 8'd1);
    repeat (40) @(posedge clk);
    #1;
    check("c4_full_rdrdy", pxMem_RD_RDY, 1'b0);
    check("c4_full_vld", px_VLD, 1'b1);
    check("c4_full_busy", busy, 1'b1);
    check("c4_full_head_col", px_col, 16'd100);
    check("c4_full_npix", got_col.size(), 0);
    px_RDY = 1'b1;
    wait_idle("c4", cyc);
    exp_addr = '{'h3000, 'h3001};
    exp_len  = '{1, 16};
    for (int i = 0; i < 16; i++) begin
      exp_col.push_back(16'd100 + COL_W'(i));
      exp_val.push_back(16'hD000 + DATA_W'(i));
    end
    compare_all("c4", 10'd1);
    check("c4_stable_while_stalled", stab_err, 0);

    // Case 5: column wrap, num_maps=0 treated as one block
    clear_logs();
    start_op("c5", 16'h4000, 10'd1023, 16'hFFFF, 8'd0);
    wait_idle("c5", cyc);
    exp_addr = '{'h4000, 'h4001};
    exp_len  = '{1, 2};
    exp_col.push_back(16'hFFFF); exp_val.push_back(16'hE001);
    exp_col.push_back(16'h0000); exp_val.push_back(16'hE002);
    compare_all("c5", 10'd1023);

    // Case 6: reset during the value burst, then case 1 again
    clear_logs();
    vld_gaps = 1'b1;
    start_op("c6", 16'h3000, 10'd2, 16'd0, 8'd1);
    for (int i = 0; i < 200 && cmd_addr.size() < 2; i++) begin
      @(posedge clk); #1;
    end
    check("c6_val_burst_seen", cmd_addr.size(), 2);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("c6_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vld_gaps = 1'b0;
    clear_logs();
    start_op("c6b", 16'hF7F7, 10'd600, 16'd5000, 8'd1);
    wait_idle("c6b", cyc);
    expect_case1();
    compare_all("c6b", 10'd600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
